// File: rtl/pcie_perf_cntrs.sv
// pcie_perf_cntrs
// Performance counters for the PCIe DPL datapath. Live counters accumulate
// events every cycle. A single-cycle iLATCH copies them, including that
// cycle's increment, into snapshot registers and clears them. Reads only
// return snapshot registers, one cycle after iRD_EN.
//
// Parameters:
//   PORTS : number of DPL buffer links
//   CTR_W : width of the event/cycle counters (2..32); the byte counter is 64b
//
// Ports:
//   clk, rst_n      : clock (rising edge), synchronous active-low reset
//   iPERF_SOP_CTR   : start-of-packet beat pulse
//   iPERF_BYTE_CTR  : one-hot beat size, [2]=32B [1]=24B [0]=16B (bits summed)
//   iPERF_RDY_N     : sink back-pressure level
//   iPERF_LINK_REQ  : per-link request-pending level
//   iPERF_LINK_DONE : per-link block-done pulse
//   iPERF_TICKS_MAX : per-link max latency, link i at [i*32 +: 32]
//   iLATCH          : snapshot-and-clear strobe
//   iRD_EN/iRD_ADDR : register read request and word address
//   oRD_DATA        : read data, held between reads
//   oRD_VALID       : read-data qualifier
//
// Build option: define PCIE_PERF_SAT_EN to make live counters saturate at
// all-ones. Without it they wrap.
module pcie_perf_cntrs #(
  parameter int PORTS = 12,
  parameter int CTR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iPERF_SOP_CTR,
  input  logic [2:0]            iPERF_BYTE_CTR,
  input  logic                  iPERF_RDY_N,
  input  logic [PORTS-1:0]      iPERF_LINK_REQ,
  input  logic [PORTS-1:0]      iPERF_LINK_DONE,
  input  logic [PORTS*32-1:0]   iPERF_TICKS_MAX,
  input  logic                  iLATCH,
  input  logic                  iRD_EN,
  input  logic [7:0]            iRD_ADDR,
  output logic [63:0]           oRD_DATA,
  output logic                  oRD_VALID
);

  function automatic logic [CTR_W-1:0] bumpCtr(input logic [CTR_W-1:0] v, input logic inc);
`ifdef PCIE_PERF_SAT_EN
    if (inc && (v != {CTR_W{1'b1}})) return v + 1'b1;
    return v;
`else
    return v + CTR_W'(inc);
`endif
  endfunction

  function automatic logic [63:0] bumpBytes(input logic [63:0] v, input logic [6:0] inc);
`ifdef PCIE_PERF_SAT_EN
    logic [64:0] sum;
    sum = {1'b0, v} + {58'd0, inc};
    return sum[64] ? {64{1'b1}} : sum[63:0];
`else
    return v + {57'd0, inc};
`endif
  endfunction

  logic [CTR_W-1:0] sopCnt_q, sopCnt_d, rdyCnt_q, rdyCnt_d, cycCnt_q, cycCnt_d;
  logic [63:0]      byteCnt_q, byteCnt_d;
  logic [CTR_W-1:0] reqCnt_q  [PORTS];
  logic [CTR_W-1:0] reqCnt_d  [PORTS];
  logic [CTR_W-1:0] doneCnt_q [PORTS];
  logic [CTR_W-1:0] doneCnt_d [PORTS];

  logic [CTR_W-1:0] sopSnap_q, rdySnap_q, cycSnap_q;
  logic [63:0]      byteSnap_q;
  logic [CTR_W-1:0] reqSnap_q   [PORTS];
  logic [CTR_W-1:0] doneSnap_q  [PORTS];
  logic [31:0]      ticksSnap_q [PORTS];

  logic [6:0]       byteInc;
  logic [63:0]      rdMux;
  logic [63:0]      rdData_q;
  logic             rdValid_q;

  // Next value of every live counter assuming no latch; the latch path
  // loads these same values into the snapshots so nothing is lost.
  always_comb begin
    byteInc = (iPERF_BYTE_CTR[2] ? 7'd32 : 7'd0)
            + (iPERF_BYTE_CTR[1] ? 7'd24 : 7'd0)
            + (iPERF_BYTE_CTR[0] ? 7'd16 : 7'd0);
    sopCnt_d  = bumpCtr(sopCnt_q, iPERF_SOP_CTR);
    rdyCnt_d  = bumpCtr(rdyCnt_q, iPERF_RDY_N);
    cycCnt_d  = bumpCtr(cycCnt_q, 1'b1);
    byteCnt_d = bumpBytes(byteCnt_q, byteInc);
    for (int i = 0; i < PORTS; i++) begin
      reqCnt_d[i]  = bumpCtr(reqCnt_q[i], iPERF_LINK_REQ[i]);
      doneCnt_d[i] = bumpCtr(doneCnt_q[i], iPERF_LINK_DONE[i]);
    end
  end

  // Read mux looks at the current snapshot registers, so a read issued in
  // the latch cycle returns the pre-latch snapshot.
  always_comb begin
    rdMux = '0;
    if (iRD_ADDR == 8'h00) rdMux = 64'(sopSnap_q);
    if (iRD_ADDR == 8'h01) rdMux = byteSnap_q;
    if (iRD_ADDR == 8'h02) rdMux = 64'(rdySnap_q);
    if (iRD_ADDR == 8'h03) rdMux = 64'(cycSnap_q);
    for (int i = 0; i < PORTS; i++) begin
      if (iRD_ADDR == 8'(16 + i)) rdMux = 64'(reqSnap_q[i]);
      if (iRD_ADDR == 8'(32 + i)) rdMux = 64'(doneSnap_q[i]);
      if (iRD_ADDR == 8'(48 + i)) rdMux = 64'(ticksSnap_q[i]);
    end
  end

  // Counter, snapshot and read-port registers. Reset wins over latch and read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sopCnt_q   <= '0;
      rdyCnt_q   <= '0;
      cycCnt_q   <= '0;
      byteCnt_q  <= '0;
      sopSnap_q  <= '0;
      rdySnap_q  <= '0;
      cycSnap_q  <= '0;
      byteSnap_q <= '0;
      for (int i = 0; i < PORTS; i++) begin
        reqCnt_q[i]    <= '0;
        doneCnt_q[i]   <= '0;
        reqSnap_q[i]   <= '0;
        doneSnap_q[i]  <= '0;
        ticksSnap_q[i] <= '0;
      end
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      if (iLATCH) begin
        sopSnap_q  <= sopCnt_d;
        rdySnap_q  <= rdyCnt_d;
        cycSnap_q  <= cycCnt_d;
        byteSnap_q <= byteCnt_d;
        sopCnt_q   <= '0;
        rdyCnt_q   <= '0;
        cycCnt_q   <= '0;
        byteCnt_q  <= '0;
        for (int i = 0; i < PORTS; i++) begin
          reqSnap_q[i]   <= reqCnt_d[i];
          doneSnap_q[i]  <= doneCnt_d[i];
          ticksSnap_q[i] <= iPERF_TICKS_MAX[i*32 +: 32];
          reqCnt_q[i]    <= '0;
          doneCnt_q[i]   <= '0;
        end
      end else begin
        sopCnt_q  <= sopCnt_d;
        rdyCnt_q  <= rdyCnt_d;
        cycCnt_q  <= cycCnt_d;
        byteCnt_q <= byteCnt_d;
        for (int i = 0; i < PORTS; i++) begin
          reqCnt_q[i]  <= reqCnt_d[i];
          doneCnt_q[i] <= doneCnt_d[i];
        end
      end
      rdValid_q <= iRD_EN;
      if (iRD_EN) rdData_q <= rdMux;
    end
  end

  assign oRD_DATA  = rdData_q;
  assign oRD_VALID = rdValid_q;

endmodule
